// File: rtl/sev_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment codes,
// the nibble encoder and the conversion FSM state type.
package sev_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    // Active-high pattern, bit6 = segment a ... bit0 = segment g.
    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        logic [6:0] code;
        code = SEG_BLANK;
        case (nibble)
            4'h0: code = SEG_0;
            4'h1: code = SEG_1;
            4'h2: code = SEG_2;
            4'h3: code = SEG_3;
            4'h4: code = SEG_4;
            4'h5: code = SEG_5;
            4'h6: code = SEG_6;
            4'h7: code = SEG_7;
            4'h8: code = SEG_8;
            4'h9: code = SEG_9;
            4'hA: code = SEG_A;
            4'hB: code = SEG_B;
            4'hC: code = SEG_C;
            4'hD: code = SEG_D;
            4'hE: code = SEG_E;
            4'hF: code = SEG_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: one bit per clock, MSB first, DATA_W
// iterations. done/bcd/overflow present the final iteration's result combinationally.
module bin_to_bcd_seq
    import sev_seg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_DIGITS*4-1:0] bcd,
    output logic                    overflow
);

    localparam int BCD_W = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(DATA_W);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_sh;
    logic [BCD_W-1:0]  r_bcd;
    logic [BCD_W-1:0]  w_adj;
    logic [BCD_W-1:0]  w_bcd_next;
    logic              r_ovf;
    logic              w_ovf_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_last;

    // Bits shifted out of the top nibble are multiples of 10^NUM_DIGITS, so
    // dropping them leaves value mod 10^NUM_DIGITS and flags the overflow.
    always_comb begin
        w_adj = r_bcd;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
        w_bcd_next = {w_adj[BCD_W-2:0], r_sh[DATA_W-1]};
        w_ovf_next = r_ovf | w_adj[BCD_W-1];
    end

    assign w_last = (r_state == CONV) && (r_cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start)  w_state_next = CONV;
            CONV: if (w_last) w_state_next = IDLE;
            default:          w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && start) begin
                r_sh  <= bin;
                r_bcd <= '0;
                r_ovf <= 1'b0;
                r_cnt <= '0;
            end else if (r_state == CONV) begin
                r_sh  <= r_sh << 1;
                r_bcd <= w_bcd_next;
                r_ovf <= w_ovf_next;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign busy     = (r_state == CONV);
    assign done     = w_last;
    assign bcd      = w_bcd_next;
    assign overflow = w_ovf_next;

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Clocked seven-segment controller: captures a value as hex or decimal digits
// and time-multiplexes them onto a shared segment bus with optional zero blanking.
module sev_seg_scan_ctrl
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 32,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int DW    = NUM_DIGITS * 4;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    logic                  w_busy;
    logic                  w_done;
    logic                  w_conv_ovf;
    logic [DW-1:0]         w_bcd;
    logic                  w_load_hex;
    logic                  w_load_dec;
    logic [DW-1:0]         w_hex_digits;
    logic                  w_hex_ovf;

    logic [DW-1:0]         r_digits;
    logic                  r_overflow;
    logic [PRE_W-1:0]      r_pre;
    logic [IDX_W-1:0]      r_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic [NUM_DIGITS-1:0] w_nz_above;
    logic                  w_nz_acc;
    logic [3:0]            w_cur_digit;
    logic                  w_cur_nz;
    logic                  w_cur_blank;
    logic [6:0]            w_seg_next;
    logic [NUM_DIGITS-1:0] w_an_next;

    assign w_load_hex = load & hex_mode & ~w_busy;
    assign w_load_dec = load & ~hex_mode & ~w_busy;

    bin_to_bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin_to_bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (w_load_dec),
        .bin      (value),
        .busy     (w_busy),
        .done     (w_done),
        .bcd      (w_bcd),
        .overflow (w_conv_ovf)
    );

    generate
        if (DATA_W > DW) begin : g_hex_trunc
            assign w_hex_digits = value[DW-1:0];
            assign w_hex_ovf    = |value[DATA_W-1:DW];
        end else begin : g_hex_ext
            assign w_hex_digits = DW'(value);
            assign w_hex_ovf    = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits   <= '0;
            r_overflow <= 1'b0;
        end else if (w_load_hex) begin
            r_digits   <= w_hex_digits;
            r_overflow <= w_hex_ovf;
        end else if (w_done) begin
            r_digits   <= w_bcd;
            r_overflow <= w_conv_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // w_nz_above[i]: some digit at position i or higher is non-zero.
    always_comb begin
        w_nz_above  = '0;
        w_nz_acc    = 1'b0;
        w_cur_digit = '0;
        w_cur_nz    = 1'b0;
        w_an_next   = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            w_nz_acc = w_nz_acc | (|r_digits[(NUM_DIGITS-1-k)*4 +: 4]);
            w_nz_above[NUM_DIGITS-1-k] = w_nz_acc;
        end
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            w_an_next[k] = (r_idx == IDX_W'(k));
            if (r_idx == IDX_W'(k)) begin
                w_cur_digit = r_digits[k*4 +: 4];
                w_cur_nz    = w_nz_above[k];
            end
        end
        w_cur_blank = blank_lz && (r_idx != '0) && !w_cur_nz;
        w_seg_next  = w_cur_blank ? SEG_BLANK : seg_encode(w_cur_digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_BLANK;
            r_an  <= '0;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign busy     = w_busy;
    assign overflow = r_overflow;
    assign seg      = (ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign an       = (ACTIVE_LOW != 0) ? ~r_an  : r_an;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Scoreboard bench: stimulus queues expected display frames, a monitor captures
// each full scan frame from the pins and compares it.
module tb_sev_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 16;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic          hex_mode = 1'b0;
    logic          blank_lz = 1'b0;
    logic [DW-1:0] value = '0;
    logic          busy;
    logic          overflow;
    logic [6:0]    seg;
    logic [ND-1:0] an;

    always #5 clk = ~clk;

    sev_seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .DATA_W     (DW),
        .SCAN_DIV   (SD),
        .ACTIVE_LOW (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .hex_mode (hex_mode),
        .blank_lz (blank_lz),
        .busy     (busy),
        .overflow (overflow),
        .seg      (seg),
        .an       (an)
    );

    typedef struct {
        string       name;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}, 7 bits each
        logic        ovf;
    } frame_t;

    frame_t exp_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int frames_done = 0;

    localparam logic [27:0] ALL_ZERO = {7'h7E, 7'h7E, 7'h7E, 7'h7E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: on the first cycle of digit 0 with an expectation pending,
    // capture SD*ND samples (one full frame) and compare against the queue head.
    initial begin
        logic [3:0] prev_an;
        logic [6:0] s_seen[16];
        logic [3:0] a_seen[16];
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        logic [6:0] act_seg;
        logic [3:0] act_an;
        frame_t     f;
        prev_an = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && !rst && an == 4'b0001 && prev_an != 4'b0001) begin
                f = exp_q.pop_front();
                s_seen[0] = seg;
                a_seen[0] = an;
                for (int c = 1; c < ND*SD; c++) begin
                    @(negedge clk);
                    s_seen[c] = seg;
                    a_seen[c] = an;
                end
                prev_an = an;
                for (int d = 0; d < ND; d++) begin
                    exp_seg = f.segs[d*7 +: 7];
                    exp_an  = 4'(1 << d);
                    act_seg = s_seen[d*SD];
                    act_an  = a_seen[d*SD];
                    for (int c = SD-1; c >= 0; c--) begin
                        if (s_seen[d*SD+c] !== exp_seg) act_seg = s_seen[d*SD+c];
                        if (a_seen[d*SD+c] !== exp_an)  act_an  = a_seen[d*SD+c];
                    end
                    check($sformatf("%s_seg_d%0d", f.name, d), 32'(act_seg), 32'(exp_seg));
                    check($sformatf("%s_an_d%0d", f.name, d), 32'(act_an), 32'(exp_an));
                end
                check($sformatf("%s_ovf", f.name), 32'(overflow), 32'(f.ovf));
                frames_done++;
            end else begin
                prev_an = an;
            end
        end
    end

    task automatic do_load(input logic [DW-1:0] v, input logic hx);
        @(negedge clk);
        value    = v;
        hex_mode = hx;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Called at #1 after the load edge; counts edges until busy drops.
    task automatic wait_conv(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    task automatic expect_frame(input string name, input logic [27:0] segs, input logic ovf);
        frame_t f;
        int target;
        int n;
        repeat (2) @(posedge clk);
        f.name = name;
        f.segs = segs;
        f.ovf  = ovf;
        target = frames_done + 1;
        exp_q.push_back(f);
        n = 0;
        while (frames_done < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (frames_done < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_frame_timeout: no frame after %0d cycles, expected one", name, n);
            exp_q.delete();
        end
    endtask

    task automatic dec_case(input string name, input logic [DW-1:0] v,
                            input logic [27:0] segs, input logic ovf);
        do_load(v, 1'b0);
        wait_conv(name, DW);
        expect_frame(name, segs, ovf);
    endtask

    initial begin
        int n;
        #3;
        check("rst_seg", 32'(seg), 32'h00);
        check("rst_an", 32'(an), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_an", 32'(an), 32'h1);
        check("rel_seg", 32'(seg), 32'h7E);
        check("rel_busy", 32'(busy), 32'h0);
        expect_frame("reset_frame", ALL_ZERO, 1'b0);

        dec_case("dec_1234", 16'd1234, {7'h30, 7'h6D, 7'h79, 7'h33}, 1'b0);
        dec_case("dec_10000", 16'd10000, ALL_ZERO, 1'b1);

        do_load(16'hBEEF, 1'b1);
        check("hex_busy", 32'(busy), 32'h0);
        check("hex_ovf_now", 32'(overflow), 32'h0);
        expect_frame("hex_beef", {7'h1F, 7'h4F, 7'h4F, 7'h47}, 1'b0);

        dec_case("dec_9999", 16'd9999, {7'h7B, 7'h7B, 7'h7B, 7'h7B}, 1'b0);
        dec_case("dec_65535", 16'd65535, {7'h5B, 7'h5B, 7'h79, 7'h5B}, 1'b1);

        @(negedge clk);
        blank_lz = 1'b1;
        dec_case("blank_7", 16'd7, {7'h00, 7'h00, 7'h00, 7'h70}, 1'b0);
        dec_case("blank_0", 16'd0, {7'h00, 7'h00, 7'h00, 7'h7E}, 1'b0);
        @(negedge clk);
        blank_lz = 1'b0;
        expect_frame("unblank_0", ALL_ZERO, 1'b0);
        @(negedge clk);
        blank_lz = 1'b1;
        dec_case("blank_1005", 16'd1005, {7'h30, 7'h7E, 7'h7E, 7'h5B}, 1'b0);
        do_load(16'h00A0, 1'b1);
        expect_frame("blank_hex_a0", {7'h00, 7'h00, 7'h77, 7'h7E}, 1'b0);
        @(negedge clk);
        blank_lz = 1'b0;

        // Second load three cycles after the first must be ignored.
        do_load(16'd55, 1'b0);
        n = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        value = 16'd99;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        n++;
        check("ignore_busy_mid", 32'(busy), 32'h1);
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ignore_busy_cycles", 32'(n), 32'(DW));
        expect_frame("ignore_55", {7'h7E, 7'h7E, 7'h5B, 7'h5B}, 1'b0);

        do_load(16'd42, 1'b0);
        wait_conv("b2b_42", DW);
        do_load(16'd321, 1'b0);
        check("b2b_accept", 32'(busy), 32'h1);
        wait_conv("b2b_321", DW);
        expect_frame("b2b_321", {7'h7E, 7'h79, 7'h6D, 7'h30}, 1'b0);

        do_load(16'd8888, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_seg", 32'(seg), 32'h00);
        check("abort_an", 32'(an), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_rel_an", 32'(an), 32'h1);
        check("abort_rel_busy", 32'(busy), 32'h0);
        check("abort_rel_seg", 32'(seg), 32'h7E);
        expect_frame("abort_frame", ALL_ZERO, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
